// File: rtl/matmul_pkg.sv
// Shared types and sizing for the matmul BRAM stream reader.
// Reader FSM states and output FIFO geometry live here.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

    localparam int READER_FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W        = $clog2(READER_FIFO_DEPTH);
    localparam int FIFO_CNT_W        = FIFO_PTR_W + 1;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, BRAM read port and output stream of the BRAM stream reader.
// The stride signal exists only when BRAM_STREAM_READER_STRIDE_EN is defined.
interface bram_stream_reader_if #(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 32
);

    logic                       start;
    logic [BRAM_ADDR_WIDTH-1:0] base_addr;
    logic [BRAM_ADDR_WIDTH:0]   length;
    logic                       busy;
    logic                       done;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
    logic [BRAM_DATA_WIDTH-1:0] bram_dout;
    // Stream: a word moves when out_valid && out_ready at a rising edge; once
    // out_valid is high it stays high with out_data stable until that happens.
    logic [BRAM_DATA_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;

`ifdef BRAM_STREAM_READER_STRIDE_EN
    logic [BRAM_ADDR_WIDTH-1:0] stride;

    modport master (
        input  start, base_addr, length, stride, bram_dout, out_ready,
        output busy, done, rd_addr, out_data, out_valid
    );
    modport slave (
        output start, base_addr, length, stride, bram_dout, out_ready,
        input  busy, done, rd_addr, out_data, out_valid
    );
`else
    modport master (
        input  start, base_addr, length, bram_dout, out_ready,
        output busy, done, rd_addr, out_data, out_valid
    );
    modport slave (
        output start, base_addr, length, bram_dout, out_ready,
        input  busy, done, rd_addr, out_data, out_valid
    );
`endif

endinterface

// File: rtl/stream_fifo.sv
// Small synchronous FIFO holding BRAM words awaiting stream transfer.
module stream_fifo
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [FIFO_CNT_W-1:0] count_o
);

    logic [DATA_WIDTH-1:0] mem_q [READER_FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == FIFO_CNT_W'(READER_FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < READER_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a BRAM address range and streams the words out through a credit-gated FIFO.
// Define BRAM_STREAM_READER_STRIDE_EN to add a latched address stride (default step 1).
module bram_stream_reader
    import matmul_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    bram_stream_reader_if.master bus,
    output reader_state_t        dbg_state_o
);

    localparam int AW = BRAM_ADDR_WIDTH;

    reader_state_t             state_q, state_d;
    logic [AW-1:0]             addr_q, addr_d;
    logic [AW-1:0]             step;
    logic [AW:0]               rem_q, rem_d;
    logic                      done_q, done_d;
    logic                      iss_q, v1_q, issue;
    logic [FIFO_CNT_W-1:0]     fifo_count, credit_sum;
    logic                      fifo_full, fifo_empty, pop, credit_ok;
    logic [BRAM_DATA_WIDTH-1:0] fifo_dout;

`ifdef BRAM_STREAM_READER_STRIDE_EN
    logic [AW-1:0] stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = AW'(1);
`endif

    // iss_q/v1_q track a read through the BRAM's registered output: a slot is
    // reserved at issue so the FIFO can never overflow.
    assign pop        = !fifo_empty && bus.out_ready;
    assign credit_sum = fifo_count + {{(FIFO_CNT_W-1){1'b0}}, iss_q}
                                   + {{(FIFO_CNT_W-1){1'b0}}, v1_q};
    assign credit_ok  = !fifo_full && (credit_sum < FIFO_CNT_W'(READER_FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        issue   = 1'b0;
`ifdef BRAM_STREAM_READER_STRIDE_EN
        stride_d = stride_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        addr_d  = bus.base_addr;
                        rem_d   = bus.length - (AW+1)'(1);
                        state_d = RUN;
`ifdef BRAM_STREAM_READER_STRIDE_EN
                        stride_d = bus.stride;
`endif
                    end
                end
            end
            RUN: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + step;
                    rem_d  = rem_q - (AW+1)'(1);
                    if (rem_q == (AW+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!iss_q && !v1_q && fifo_count == FIFO_CNT_W'(1) && pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            iss_q   <= 1'b0;
            v1_q    <= 1'b0;
`ifdef BRAM_STREAM_READER_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            iss_q   <= issue;
            v1_q    <= iss_q;
`ifdef BRAM_STREAM_READER_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    stream_fifo #(.DATA_WIDTH(BRAM_DATA_WIDTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (v1_q),
        .pop_i   (pop),
        .data_i  (bus.bram_dout),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.rd_addr   = addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_dout;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM holding word[a] = a.
module tb_bram_stream_reader;
    import matmul_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    reader_state_t dbg_state;
    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];

    bram_stream_reader_if #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) bus ();

    bram_stream_reader #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset / BRAM model ----------------
    always #5 clock = ~clock;

    initial for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);

    always @(posedge clock) bus.bram_dout <= mem[bus.rd_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.out_ready = 1'b0;
`ifdef BRAM_STREAM_READER_STRIDE_EN
        bus.stride    = '0;
`endif
    endtask

    task automatic issue_start(input logic [AW-1:0] base, input logic [AW:0] len,
                               input logic [AW-1:0] stride);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
`ifdef BRAM_STREAM_READER_STRIDE_EN
        bus.stride    = stride;
`else
        if (stride != AW'(1)) $display("note: stride %0d ignored without stride build", stride);
`endif
    endtask

    // Full transfer with out_ready held high; cycle-exact address, data, done.
    task automatic stream_and_check(input string tag, input logic [AW-1:0] base,
                                    input logic [AW:0] len, input logic [AW-1:0] stride);
        logic [AW-1:0] a;
        int n;
        n = int'(len);
        @(negedge clock);
        issue_start(base, len, stride);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc <= n + 2; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (cyc < n) begin
                a = base + AW'(cyc) * stride;
                total_cnt++;
                if (bus.rd_addr !== a) $display("FAIL %s_rd_addr[%0d]: got %h want %h", tag, cyc, bus.rd_addr, a);
                else pass_cnt++;
            end
            if (cyc >= 2 && cyc < n + 2) begin
                a = base + AW'(cyc - 2) * stride;
                total_cnt++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(a))
                    $display("FAIL %s_word[%0d]: got valid=%b data=%h want valid=1 data=%h", tag, cyc - 2, bus.out_valid, bus.out_data, DW'(a));
                else pass_cnt++;
            end else begin
                total_cnt++;
                if (bus.out_valid !== 1'b0) $display("FAIL %s_valid_low[%0d]: got %b want 0", tag, cyc, bus.out_valid);
                else pass_cnt++;
            end
            total_cnt++;
            if (cyc == n + 2) begin
                if (bus.done !== 1'b1 || bus.busy !== 1'b0)
                    $display("FAIL %s_done: got done=%b busy=%b want done=1 busy=0", tag, bus.done, bus.busy);
                else pass_cnt++;
            end else begin
                if (bus.done !== 1'b0 || bus.busy !== 1'b1)
                    $display("FAIL %s_busy[%0d]: got done=%b busy=%b want done=0 busy=1", tag, cyc, bus.done, bus.busy);
                else pass_cnt++;
            end
        end
        @(negedge clock);
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL %s_done_pulse: got %b want 0", tag, bus.done);
        else pass_cnt++;
        bus.out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        repeat (2) @(negedge clock);
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_status: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_addr !== '0) $display("FAIL reset_rd_addr: got %h want 000", bus.rd_addr);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0)
            $display("FAIL reset_stream: got valid=%b data=%h want 0 0", bus.out_valid, bus.out_data);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_contiguous();
        stream_and_check("contig", 10'h010, 11'd8, 10'd1);
    endtask

    task automatic test_backpressure();
        logic [3:0]    pat = 4'b1001;
        logic          ready, prev_stall, got_done;
        logic [DW-1:0] held, exp_w;
        int            max_cnt;
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back(DW'(32'h40 + i));
        prev_stall = 1'b0;
        got_done   = 1'b0;
        held       = '0;
        max_cnt    = 0;
        @(negedge clock);
        issue_start(10'h040, 11'd6, 10'd1);
        for (int t = 0; t < 60 && !got_done; t++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (prev_stall) begin
                    total_cnt++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== held)
                        $display("FAIL bp_hold[%0d]: got valid=%b data=%h want valid=1 data=%h", t, bus.out_valid, bus.out_data, held);
                    else pass_cnt++;
                end
                ready = pat[t % 4];
                bus.out_ready = ready;
                if (bus.out_valid === 1'b1 && ready) begin
                    total_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL bp_extra_word: got %h want none", bus.out_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (bus.out_data !== exp_w) $display("FAIL bp_word: got %h want %h", bus.out_data, exp_w);
                        else pass_cnt++;
                    end
                end
                prev_stall = (bus.out_valid === 1'b1) && !ready;
                held       = bus.out_data;
            end
        end
        total_cnt++;
        if (!got_done || exp_q.size() != 0)
            $display("FAIL bp_complete: got done=%b left=%0d want done=1 left=0", got_done, exp_q.size());
        else pass_cnt++;
        total_cnt++;
        if (max_cnt > READER_FIFO_DEPTH) $display("FAIL bp_fifo_bound: got %0d want <=4", max_cnt);
        else pass_cnt++;
        bus.out_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_stall_full();
        @(negedge clock);
        issue_start(10'h060, 11'd8, 10'd1);
        bus.out_ready = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (8) @(negedge clock);
        total_cnt++;
        if (dut.u_fifo.count_o !== 3'd4) $display("FAIL stall_fifo_count: got %0d want 4", dut.u_fifo.count_o);
        else pass_cnt++;
        total_cnt++;
        if (bus.rd_addr !== 10'h063) $display("FAIL stall_rd_addr: got %h want 063", bus.rd_addr);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(32'h60 + i))
                $display("FAIL stall_resume[%0d]: got valid=%b data=%h want valid=1 data=%h", i, bus.out_valid, bus.out_data, DW'(32'h60 + i));
            else pass_cnt++;
            @(negedge clock);
        end
        total_cnt++;
        if (bus.done !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL stall_done: got done=%b valid=%b want 1 0", bus.done, bus.out_valid);
        else pass_cnt++;
        bus.out_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_wrap();
        stream_and_check("wrap", 10'h3FE, 11'd4, 10'd1);
        total_cnt++;
        if (bus.rd_addr !== 10'h001) $display("FAIL wrap_hold: got %h want 001", bus.rd_addr);
        else pass_cnt++;
    endtask

    task automatic test_zero_length();
        logic [AW-1:0] addr_before;
        addr_before = 10'h001;
        @(negedge clock);
        issue_start(10'h155, 11'd0, 10'd1);
        @(negedge clock);
        bus.start = 1'b0;
        total_cnt++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL zero_done: got done=%b busy=%b want 1 0", bus.done, bus.busy);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.rd_addr !== addr_before || bus.out_valid !== 1'b0)
                $display("FAIL zero_quiet[%0d]: got rd_addr=%h valid=%b want %h 0", i, bus.rd_addr, bus.out_valid, addr_before);
            else pass_cnt++;
            @(negedge clock);
            total_cnt++;
            if (bus.done !== 1'b0) $display("FAIL zero_done_once[%0d]: got %b want 0", i, bus.done);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_while_busy();
        logic          got_done;
        logic [DW-1:0] exp_w;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(DW'(32'h20 + i));
        got_done = 1'b0;
        @(negedge clock);
        issue_start(10'h020, 11'd3, 10'd1);
        bus.out_ready = 1'b0;
        @(negedge clock);
        issue_start(10'h100, 11'd5, 10'd1);
        @(negedge clock);
        @(negedge clock);
        drive_idle();
        repeat (3) @(negedge clock);
        total_cnt++;
        if (bus.busy !== 1'b1 || bus.rd_addr !== 10'h022)
            $display("FAIL busy_ignore: got busy=%b rd_addr=%h want 1 022", bus.busy, bus.rd_addr);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            if (bus.out_valid === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL busy_extra_word: got %h want none", bus.out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.out_data !== exp_w) $display("FAIL busy_word: got %h want %h", bus.out_data, exp_w);
                    else pass_cnt++;
                end
            end
            @(negedge clock);
        end
        total_cnt++;
        if (!got_done || exp_q.size() != 0)
            $display("FAIL busy_complete: got done=%b left=%0d want 1 0", got_done, exp_q.size());
        else pass_cnt++;
        repeat (3) begin
            @(negedge clock);
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
                $display("FAIL busy_no_second: got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
            else pass_cnt++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        issue_start(10'h080, 11'd10, 10'd1);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc <= 4; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        total_cnt++;
        if (bus.out_data !== 32'h82) $display("FAIL mid_third_word: got %h want 00000082", bus.out_data);
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_addr !== '0)
            $display("FAIL mid_reset_ctrl: got busy=%b done=%b rd_addr=%h want 0 0 000", bus.busy, bus.done, bus.rd_addr);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || dbg_state !== IDLE)
            $display("FAIL mid_reset_stream: got valid=%b data=%h state=%0d want 0 0 0", bus.out_valid, bus.out_data, dbg_state);
        else pass_cnt++;
        drive_idle();
        @(negedge clock);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            total_cnt++;
            if (bus.out_valid !== 1'b0 || bus.done !== 1'b0)
                $display("FAIL mid_quiet: got valid=%b done=%b want 0 0", bus.out_valid, bus.done);
            else pass_cnt++;
        end
        stream_and_check("after_reset", 10'h080, 11'd10, 10'd1);
    endtask

`ifdef BRAM_STREAM_READER_STRIDE_EN
    task automatic test_stride();
        stream_and_check("stride4", 10'd2, 11'd4, 10'd4);
        stream_and_check("stride0", 10'd5, 11'd3, 10'd0);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_contiguous();
        test_backpressure();
        test_stall_full();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid();
`ifdef BRAM_STREAM_READER_STRIDE_EN
        test_stride();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
